// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman table pipeline: default field widths,
// sorter state encoding and the canonical sort-key comparison.
package huffman_pkg;

  localparam int DEF_CODE_SIZE_WIDTH = 5;
  localparam int DEF_SYMBOL_ID_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Fields are zero-extended to this width so one function serves every instance width.
  localparam int KEY_FIELD_W = 16;

  function automatic logic key_greater(
    input logic [KEY_FIELD_W-1:0] size_a,
    input logic [KEY_FIELD_W-1:0] id_a,
    input logic [KEY_FIELD_W-1:0] size_b,
    input logic [KEY_FIELD_W-1:0] id_b,
    input logic                   zero_last
  );
    logic unused_a;
    logic unused_b;
    unused_a = zero_last && (size_a == 16'd0);
    unused_b = zero_last && (size_b == 16'd0);
    return {unused_a, size_a, id_a} > {unused_b, size_b, id_b};
  endfunction

endpackage

// File: rtl/cmp_exch_cell.sv
// Combinational compare-exchange of one adjacent (size, id) pair; the pair
// leaves ordered by the canonical key and 'swapped' reports an exchange.
module cmp_exch_cell
  import huffman_pkg::*;
#(
  parameter int CODE_SIZE_WIDTH = DEF_CODE_SIZE_WIDTH,
  parameter int SYMBOL_ID_WIDTH = DEF_SYMBOL_ID_WIDTH
) (
  input  logic [CODE_SIZE_WIDTH-1:0] size_a,
  input  logic [SYMBOL_ID_WIDTH-1:0] id_a,
  input  logic [CODE_SIZE_WIDTH-1:0] size_b,
  input  logic [SYMBOL_ID_WIDTH-1:0] id_b,
  input  logic                       zero_last,
  output logic [CODE_SIZE_WIDTH-1:0] size_lo,
  output logic [SYMBOL_ID_WIDTH-1:0] id_lo,
  output logic [CODE_SIZE_WIDTH-1:0] size_hi,
  output logic [SYMBOL_ID_WIDTH-1:0] id_hi,
  output logic                       swapped
);

  logic gt_s;

  assign gt_s = key_greater(KEY_FIELD_W'(size_a), KEY_FIELD_W'(id_a),
                            KEY_FIELD_W'(size_b), KEY_FIELD_W'(id_b), zero_last);

  // Equal keys stay in place, so duplicates never swap.
  always_comb begin
    if (gt_s) begin
      size_lo = size_b;
      id_lo   = id_b;
      size_hi = size_a;
      id_hi   = id_a;
    end else begin
      size_lo = size_a;
      id_lo   = id_a;
      size_hi = size_b;
      id_hi   = id_b;
    end
    swapped = gt_s;
  end

endmodule

// File: rtl/code_size_sorter_oets.sv
// Iterative odd-even transposition sorter for Huffman code-length tables with
// early termination after two consecutive swap-free phases.
module code_size_sorter_oets
  import huffman_pkg::*;
#(
  parameter int SYMBOLS         = 16,
  parameter int CODE_SIZE_WIDTH = DEF_CODE_SIZE_WIDTH,
  parameter int SYMBOL_ID_WIDTH = DEF_SYMBOL_ID_WIDTH,
  parameter int COUNT_WIDTH     = $clog2(SYMBOLS + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 zero_last,
  input  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   code_size_flat,
  input  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   symbol_id_flat,
  output logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   sorted_code_size_flat,
  output logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   sorted_symbol_id_flat,
  output logic [COUNT_WIDTH-1:0]               valid_count,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CW = CODE_SIZE_WIDTH;
  localparam int IW = SYMBOL_ID_WIDTH;
  localparam int PW = (SYMBOLS > 2) ? $clog2(SYMBOLS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(SYMBOLS - 1);

  logic [1:0]             state_r;
  logic [PW-1:0]          phase_r;
  logic                   noswap_prev_r;
  logic                   zero_last_r;
  logic                   busy_r;
  logic                   done_r;
  logic [COUNT_WIDTH-1:0] valid_count_r;
  logic [CW-1:0]          size_r     [SYMBOLS];
  logic [IW-1:0]          id_r       [SYMBOLS];
  logic [CW-1:0]          size_nxt_s [SYMBOLS];
  logic [IW-1:0]          id_nxt_s   [SYMBOLS];
  logic [CW-1:0]          lo_size_s  [SYMBOLS-1];
  logic [IW-1:0]          lo_id_s    [SYMBOLS-1];
  logic [CW-1:0]          hi_size_s  [SYMBOLS-1];
  logic [IW-1:0]          hi_id_s    [SYMBOLS-1];
  logic [SYMBOLS-2:0]     swap_s;
  logic [SYMBOLS-2:0]     act_swap_s;
  logic                   any_swap_s;
  logic                   finish_s;
  logic [COUNT_WIDTH-1:0] cnt_s;

  // One cell per adjacent pair; phase parity decides which results are kept.
  for (genvar i = 0; i < SYMBOLS - 1; i++) begin : g_cell
    localparam logic PAR = ((i % 2) == 1);
    cmp_exch_cell #(
      .CODE_SIZE_WIDTH(CW),
      .SYMBOL_ID_WIDTH(IW)
    ) u_cell (
      .size_a    (size_r[i]),
      .id_a      (id_r[i]),
      .size_b    (size_r[i+1]),
      .id_b      (id_r[i+1]),
      .zero_last (zero_last_r),
      .size_lo   (lo_size_s[i]),
      .id_lo     (lo_id_s[i]),
      .size_hi   (hi_size_s[i]),
      .id_hi     (hi_id_s[i]),
      .swapped   (swap_s[i])
    );
    assign act_swap_s[i] = swap_s[i] & (phase_r[0] == PAR);
  end

  // Each slot takes the result of whichever pair it belongs to in this phase.
  for (genvar j = 0; j < SYMBOLS; j++) begin : g_next
    localparam logic PAR = ((j % 2) == 1);
    if (j == 0) begin : g_first
      assign size_nxt_s[j] = (phase_r[0] == 1'b0) ? lo_size_s[j] : size_r[j];
      assign id_nxt_s[j]   = (phase_r[0] == 1'b0) ? lo_id_s[j]   : id_r[j];
    end else if (j == SYMBOLS - 1) begin : g_last
      assign size_nxt_s[j] = (phase_r[0] != PAR) ? hi_size_s[j-1] : size_r[j];
      assign id_nxt_s[j]   = (phase_r[0] != PAR) ? hi_id_s[j-1]   : id_r[j];
    end else begin : g_mid
      assign size_nxt_s[j] = (phase_r[0] == PAR) ? lo_size_s[j] : hi_size_s[j-1];
      assign id_nxt_s[j]   = (phase_r[0] == PAR) ? lo_id_s[j]   : hi_id_s[j-1];
    end
    assign sorted_code_size_flat[j*CW +: CW] = size_r[j];
    assign sorted_symbol_id_flat[j*IW +: IW] = id_r[j];
  end

  assign any_swap_s = |act_swap_s;
  assign finish_s   = (phase_r == LAST_PHASE) ||
                      ((phase_r != {PW{1'b0}}) && !any_swap_s && noswap_prev_r);

  // Count of used symbols among the entries being offered for capture.
  always_comb begin
    cnt_s = {COUNT_WIDTH{1'b0}};
    for (int i = 0; i < SYMBOLS; i++) begin
      cnt_s = cnt_s + COUNT_WIDTH'(code_size_flat[i*CW +: CW] != {CW{1'b0}});
    end
  end

  // Control FSM, capture and per-phase write-back of the working arrays.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      phase_r       <= {PW{1'b0}};
      noswap_prev_r <= 1'b0;
      zero_last_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      valid_count_r <= {COUNT_WIDTH{1'b0}};
      for (int i = 0; i < SYMBOLS; i++) begin
        size_r[i] <= {CW{1'b0}};
        id_r[i]   <= {IW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (enable) begin
            state_r       <= ST_SORT;
            phase_r       <= {PW{1'b0}};
            noswap_prev_r <= 1'b0;
            zero_last_r   <= zero_last;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            valid_count_r <= cnt_s;
            for (int i = 0; i < SYMBOLS; i++) begin
              size_r[i] <= code_size_flat[i*CW +: CW];
              id_r[i]   <= symbol_id_flat[i*IW +: IW];
            end
          end
        end
        ST_SORT: begin
          for (int i = 0; i < SYMBOLS; i++) begin
            size_r[i] <= size_nxt_s[i];
            id_r[i]   <= id_nxt_s[i];
          end
          phase_r       <= phase_r + PW'(1);
          noswap_prev_r <= !any_swap_s;
          if (finish_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_count = valid_count_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: doc/code_size_sorter_oets.md
# code_size_sorter_oets

Parametrised, iterative sorter for Huffman code-length tables. It captures a flat vector of (code size, symbol ID) pairs and reorders them into ascending code size. Ties break by ascending symbol ID, giving deterministic canonical order. Generalises the fixed 16-symbol sorter with:
- configurable symbol count;
- an odd-even transposition core with early termination;
- an optional "unused symbols last" mode;
- a count of used symbols.

It sits between the code-size generator and the canonical code assigner.

## Interface
- SYMBOLS, 16, number of entries; ≥2.
- CODE_SIZE_WIDTH, 5, bits per code size.
- SYMBOL_ID_WIDTH, 4, bits per symbol ID; ≥ clog2(SYMBOLS).
- COUNT_WIDTH, clog2(SYMBOLS+1), width of valid_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  start strobe; sampled only in IDLE or DONE.
- zero_last  in  1  mode; 1 = code size 0 marks an unused symbol, sorted after all used ones. Captured with the data.
- code_size_flat  in  SYMBOLS*CODE_SIZE_WIDTH  entry i at [i*CODE_SIZE_WIDTH +: CODE_SIZE_WIDTH].
- symbol_id_flat  in  SYMBOLS*SYMBOL_ID_WIDTH  entry i at [i*SYMBOL_ID_WIDTH +: SYMBOL_ID_WIDTH].
- sorted_code_size_flat  out  SYMBOLS*CODE_SIZE_WIDTH  working array; valid while done=1; index 0 = smallest key.
- sorted_symbol_id_flat  out  SYMBOLS*SYMBOL_ID_WIDTH  companion IDs, same ordering.
- valid_count  out  COUNT_WIDTH  number of captured entries with non-zero code size.
- busy  out  1  high while in SORT.
- done  out  1  high in DONE; held until next accepted enable or reset.

## Operation
- States: IDLE, SORT, DONE.
- Transitions:
  - IDLE→SORT on enable.
  - SORT→DONE on completion.
  - DONE→SORT on enable.
  - Enable in SORT is ignored.
- Capture (edge accepting enable):
  - load both arrays and latch zero_last;
  - valid_count ← popcount(size≠0);
  - clear phase counter and the no-swap flag.
- Sort key per entry: {zero_last_latched && size==0, size, id}. Comparison is unsigned and ascending. The key is never stored; it is recomputed from the array.
- Phase p (one per SORT cycle):
  - p even: compare-exchange pairs (0,1),(2,3),…
  - p odd: compare-exchange pairs (1,2),(3,4),…
  - Swap when key[lo] > key[lo+1]. Size and ID move together.
  - An unpaired end element is untouched.
- Completion, whichever comes first:
  - phase SYMBOLS-1 executed; or
  - phase p≥1 with no swap in phase p and in phase p-1.
- Duplicate (size, id) pairs are legal. Equal keys are never swapped.
- Reset mid-sort: immediate return to IDLE; arrays, valid_count, busy and done all become 0.

## Timing
- Reset values: all outputs 0; state IDLE.
- Enable accepted at edge T:
  - after T: busy=1, done=0, arrays hold the inputs;
  - phase 0 executes at edge T+1, phase p at edge T+1+p.
- The edge executing the final phase also sets state DONE, busy=0, done=1.
- Latency bounds:
  - worst case: done high after edge T+SYMBOLS;
  - best case (input already in order): done high after edge T+2.
- Outputs are stable throughout DONE.
- New enable in DONE at edge U: done=0 and busy=1 after U. Data from U is captured.

## Structure
Shared package huffman_pkg holds:
- default CODE_SIZE_WIDTH and SYMBOL_ID_WIDTH;
- state encoding constants (IDLE=0, SORT=1, DONE=2);
- a key-compare function taking (size_a, id_a, size_b, id_b, zero_last) and returning "a greater than b".

One sub-module, cmp_exch_cell:
- combinational;
- inputs: two (size, id) pairs plus zero_last;
- outputs: ordered pair and a swapped flag.
- SYMBOLS-1 instances cover every adjacent pair. Phase parity selects which instances' results are written back; the others are ignored. The no-swap flag is the NOR of the active instances' swapped flags.

## Test plan
- Mixed input, zero_last=0:
  - sizes {10,3,7,2,15,8,5,1,14,6,4,12,9,0,11,13}, ids {4,1,2,6,0,8,3,9,10,11,5,7,12,13,14,15};
  - required: sizes 0..15 in order; ids 13,9,6,1,5,3,11,2,8,12,4,14,7,15,10,0; valid_count=15; done within 16 cycles of capture.
- Same input, zero_last=1 → sizes 1..15 occupy slots 0..14 with ids 9,6,1,…,0; slot 15 = (0, 13); valid_count=15.
- All sizes 4, ids 15..0 → ids 0..15 ascending; full 16 phases (done after edge T+16).
- Already sorted input → done after edge T+2; arrays unchanged.
- Unchanged from above:
  - Assert enable 3 cycles into SORT → ignored; result matches the first capture.
  - Assert reset at phase 5 → all outputs 0 the same cycle; next enable sorts correctly.
- SYMBOLS=7, reverse-ordered sizes 7..1 → ascending 1..7; unpaired end element handled; done within 7 phases.
